countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter DIV, default 500000, is the number of ClkIn cycles per count tick (100 ms at 5 MHz); legal range 2..2^20.
REQ-002 Parameter SEG_POL, default 1, sets segment polarity: 1 = segment lit at logic 1, 0 = segment lit at logic 0.
REQ-003 ClkIn  input  1  single system clock; all state updates on rising edge.
REQ-004 nRst  input  1  asynchronous, active-low reset.
REQ-005 Load  input  1  synchronous request to load LoadVal into the count register.
REQ-006 LoadVal  input  8  countdown start value, in ticks.
REQ-007 Start  input  1  synchronous request to start or resume counting.
REQ-008 Stop  input  1  synchronous request to pause counting.
REQ-009 DigitH  output  [0:6]  seven-segment pattern for count[7:4]; index 0 = segment a ... index 6 = segment g.
REQ-010 DigitL  output  [0:6]  seven-segment pattern for count[3:0], same bit order.
REQ-011 Done  output  1  registered flag, high while the FSM is in DONE.

Function
REQ-012 The block SHALL hold an 8-bit count register and a tick prescaler counting 0..DIV-1.
REQ-013 The prescaler SHALL advance only in RUN, SHALL be cleared to 0 on every entry to RUN and on Load, and SHALL issue a one-cycle tick when it equals DIV-1, then wrap to 0.
REQ-014 The FSM SHALL have the states IDLE, RUN, PAUSE and DONE.
REQ-015 Input priority per cycle SHALL be Load > Stop > Start.
REQ-016 Load in any state SHALL write count := LoadVal, move the FSM to IDLE, and clear Done on the next edge.
REQ-017 Start in IDLE or PAUSE with count != 0 SHALL move the FSM to RUN.
REQ-018 Start with count == 0, or while in DONE, SHALL be ignored.
REQ-019 Stop in RUN SHALL move the FSM to PAUSE with count and prescaler frozen; resuming SHALL restart the prescaler from 0.
REQ-020 A tick in RUN SHALL decrement count by 1.
REQ-021 A tick in RUN with count == 1 SHALL set count to 0, move the FSM to DONE, and set Done on the same edge.
REQ-022 Count SHALL never wrap below 0.
REQ-023 DONE SHALL persist until Load or reset.
REQ-024 First-tick latency after Start SHALL be exactly DIV cycles.
REQ-025 DigitH and DigitL SHALL be combinational hex decodes (0-F) of the registered count, with polarity set by SEG_POL.
REQ-026 Stop and Start asserted together in RUN SHALL give PAUSE (Stop wins).

Reset
REQ-027 On nRst low, immediately and independent of ClkIn, the block SHALL set count = 0, prescaler = 0, FSM = IDLE and Done = 0, so the digits show "00".
REQ-028 Reset asserted mid-RUN SHALL abort the countdown with no residual tick after release.
REQ-029 The first active edge after nRst deasserts SHALL evaluate inputs normally.

Configuration
REQ-030 With macro COUNTDOWN_TIMER_BLINK_EN defined, the block SHALL keep the prescaler running in DONE and blank both digits (all segments unlit) during alternating 5-tick periods, starting lit at DONE entry.
REQ-031 Without COUNTDOWN_TIMER_BLINK_EN, both digits SHALL show steady "00" in DONE and the prescaler SHALL be held at 0.
REQ-032 Done timing SHALL be identical with and without COUNTDOWN_TIMER_BLINK_EN.

Verification (DIV=4, SEG_POL=1)
REQ-033 Reset then release -> Done=0, DigitH=DigitL=1111110 ("0").
REQ-034 Load LoadVal=0x03, then Start -> count 3→2→1→0 at 4, 8 and 12 cycles after Start; Done rises on the edge of the third tick.
REQ-035 Load 0x12, Start, Stop at cycle 6 (count=0x11), wait 20 cycles, Start again -> count held at 0x11 during the wait; next decrement 4 cycles after restart.
REQ-036 Load 0x00, then Start -> FSM stays IDLE and Done stays 0; Load with Start asserted together -> count loaded and FSM in IDLE.
REQ-037 Pulse nRst low mid-RUN at count=0x05 -> count=0 and IDLE asynchronously; no tick follows.
REQ-038 With COUNTDOWN_TIMER_BLINK_EN, in DONE -> digits lit for 20 cycles, blank for 20 cycles, repeating; Load ends blinking.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable 8-bit tick countdown with a hex seven-segment display and a Done flag.
// Optional macro COUNTDOWN_TIMER_BLINK_EN blinks the digits while in DONE.
module countdown_timer #(
    parameter int DIV     = 500000,
    parameter int SEG_POL = 1
) (
    input  logic       ClkIn,
    input  logic       nRst,
    input  logic       Load,
    input  logic [7:0] LoadVal,
    input  logic       Start,
    input  logic       Stop,
    output logic [0:6] DigitH,
    output logic [0:6] DigitL,
    output logic       Done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

    state_t        stateR, nextStateS;
    logic [7:0]    countR, countS;
    logic [PW-1:0] prescR, prescS;
    logic          doneR;
    logic          prescAtMaxS;
    logic [0:6]    segHS, segLS;
`ifdef COUNTDOWN_TIMER_BLINK_EN
    logic [2:0]    blinkCntR, blinkCntS;
    logic          blankR, blankS;
`endif

    // Segment order a..g maps to index 0..6; result is active-high.
    function automatic logic [0:6] hex2seg(input logic [3:0] v);
        case (v)
            4'h0:    hex2seg = 7'b1111110;
            4'h1:    hex2seg = 7'b0110000;
            4'h2:    hex2seg = 7'b1101101;
            4'h3:    hex2seg = 7'b1111001;
            4'h4:    hex2seg = 7'b0110011;
            4'h5:    hex2seg = 7'b1011011;
            4'h6:    hex2seg = 7'b1011111;
            4'h7:    hex2seg = 7'b1110000;
            4'h8:    hex2seg = 7'b1111111;
            4'h9:    hex2seg = 7'b1111011;
            4'hA:    hex2seg = 7'b1110111;
            4'hB:    hex2seg = 7'b0011111;
            4'hC:    hex2seg = 7'b1001110;
            4'hD:    hex2seg = 7'b0111101;
            4'hE:    hex2seg = 7'b1001111;
            4'hF:    hex2seg = 7'b1000111;
            default: hex2seg = 7'b0000000;
        endcase
    endfunction

    assign prescAtMaxS = (prescR == PMAX);

    // Next-state, count and prescaler logic; Load > Stop > Start.
    always_comb begin
        nextStateS = stateR;
        countS     = countR;
        prescS     = prescR;
`ifdef COUNTDOWN_TIMER_BLINK_EN
        blinkCntS  = 3'd0;
        blankS     = 1'b0;
`endif
        if (Load) begin
            countS     = LoadVal;
            nextStateS = IDLE;
            prescS     = '0;
        end else begin
            case (stateR)
                IDLE, PAUSE: begin
                    if (!Stop && Start && (countR != 8'd0)) begin
                        nextStateS = RUN;
                        prescS     = '0;
                    end else begin
                        nextStateS = stateR;
                    end
                end
                RUN: begin
                    if (Stop) begin
                        nextStateS = PAUSE;
                    end else if (prescAtMaxS) begin
                        prescS = '0;
                        // Counts of 1 (or a stray 0) finish rather than wrap.
                        if (countR <= 8'd1) begin
                            countS     = 8'd0;
                            nextStateS = DONE;
                        end else begin
                            countS = countR - 8'd1;
                        end
                    end else begin
                        prescS = prescR + PW'(1);
                    end
                end
                DONE: begin
`ifdef COUNTDOWN_TIMER_BLINK_EN
                    blinkCntS = blinkCntR;
                    blankS    = blankR;
                    if (prescAtMaxS) begin
                        prescS = '0;
                        if (blinkCntR == 3'd4) begin
                            blinkCntS = 3'd0;
                            blankS    = ~blankR;
                        end else begin
                            blinkCntS = blinkCntR + 3'd1;
                        end
                    end else begin
                        prescS = prescR + PW'(1);
                    end
`else
                    prescS = '0;
`endif
                end
                default: begin
                    nextStateS = IDLE;
                    countS     = 8'd0;
                    prescS     = '0;
                end
            endcase
        end
    end

    // State, count, prescaler and Done registers.
    always_ff @(posedge ClkIn or negedge nRst) begin
        if (!nRst) begin
            stateR <= IDLE;
            countR <= 8'd0;
            prescR <= '0;
            doneR  <= 1'b0;
        end else begin
            stateR <= nextStateS;
            countR <= countS;
            prescR <= prescS;
            doneR  <= (nextStateS == DONE);
        end
    end

`ifdef COUNTDOWN_TIMER_BLINK_EN
    // Blink phase registers: lit for five ticks, blank for five ticks.
    always_ff @(posedge ClkIn or negedge nRst) begin
        if (!nRst) begin
            blinkCntR <= 3'd0;
            blankR    <= 1'b0;
        end else begin
            blinkCntR <= blinkCntS;
            blankR    <= blankS;
        end
    end
`endif

    // Digit decode with optional blanking and output polarity.
    always_comb begin
`ifdef COUNTDOWN_TIMER_BLINK_EN
        if (blankR) begin
            segHS = 7'b0000000;
            segLS = 7'b0000000;
        end else begin
            segHS = hex2seg(countR[7:4]);
            segLS = hex2seg(countR[3:0]);
        end
`else
        segHS = hex2seg(countR[7:4]);
        segLS = hex2seg(countR[3:0]);
`endif
        if (SEG_POL != 0) begin
            DigitH = segHS;
            DigitL = segLS;
        end else begin
            DigitH = ~segHS;
            DigitL = ~segLS;
        end
    end

    assign Done = doneR;

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven scoreboard bench for countdown_timer with DIV=4, SEG_POL=1.
module tb_countdown_timer;

    localparam int DIV = 4;

    logic       ClkIn = 1'b0;
    logic       nRst = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] LoadVal = 8'd0;
    logic       Start = 1'b0;
    logic       Stop = 1'b0;
    logic [0:6] DigitH, DigitL;
    logic       Done;

    always #5 ClkIn = ~ClkIn;

    countdown_timer #(.DIV(DIV), .SEG_POL(1)) dut (
        .ClkIn(ClkIn), .nRst(nRst), .Load(Load), .LoadVal(LoadVal),
        .Start(Start), .Stop(Stop), .DigitH(DigitH), .DigitL(DigitL), .Done(Done)
    );

    typedef struct {
        logic       ld;
        logic [7:0] val;
        logic       st;
        logic       sp;
        int         cyc;
        logic [7:0] expCnt;
        logic       expDone;
    } vec_t;

    typedef struct {
        logic [7:0] cnt;
        logic       dn;
        logic       blank;
    } exp_t;

    exp_t sb[$];
    int   nCmp = 0;
    int   nErr = 0;
    vec_t vecs[25];

    function automatic logic [0:6] seg(input logic [3:0] v);
        logic [0:6] t [16];
        t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        return t[v];
    endfunction

    task automatic pushExp(input logic [7:0] cnt, input logic dn, input logic blank);
        exp_t e;
        e.cnt = cnt; e.dn = dn; e.blank = blank;
        sb.push_back(e);
    endtask

    task automatic checkOut(input string name);
        exp_t e;
        logic [0:6] eh, el;
        nCmp++;
        if (sb.size() == 0) begin
            nErr++;
            $display("FAIL %s: scoreboard empty, got DigitH=%b DigitL=%b Done=%b", name, DigitH, DigitL, Done);
        end else begin
            e  = sb.pop_front();
            eh = e.blank ? 7'b0000000 : seg(e.cnt[7:4]);
            el = e.blank ? 7'b0000000 : seg(e.cnt[3:0]);
            if (DigitH !== eh || DigitL !== el || Done !== e.dn) begin
                nErr++;
                $display("FAIL %s: got DigitH=%b DigitL=%b Done=%b, expected DigitH=%b DigitL=%b Done=%b",
                         name, DigitH, DigitL, Done, eh, el, e.dn);
            end
        end
    endtask

    // Called at a negedge: hold inputs for one rising edge, then idle for cyc-1 edges.
    task automatic drive(input logic ld, input logic [7:0] val, input logic st, input logic sp,
                         input int cyc, input logic [7:0] expCnt, input logic expDone,
                         input logic blank, input string name);
        Load = ld; LoadVal = val; Start = st; Stop = sp;
        pushExp(expCnt, expDone, blank);
        @(negedge ClkIn);
        Load = 1'b0; Start = 1'b0; Stop = 1'b0;
        repeat (cyc - 1) @(negedge ClkIn);
        checkOut(name);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1,  8'h03, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4,  8'h03, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1,  8'h02, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3,  8'h02, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1,  8'h01, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3,  8'h01, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1,  8'h00, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5,  8'h00, 1'b1};
        vecs[8]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1,  8'h12, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5,  8'h11, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1,  8'h11, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 20, 8'h11, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 4,  8'h11, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1,  8'h10, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1,  8'h10, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8,  8'h10, 1'b0};
        vecs[16] = '{1'b1, 8'h00, 1'b0, 1'b0, 1,  8'h00, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 8,  8'h00, 1'b0};
        vecs[18] = '{1'b1, 8'h05, 1'b1, 1'b0, 8,  8'h05, 1'b0};
        vecs[19] = '{1'b1, 8'hAF, 1'b0, 1'b0, 1,  8'hAF, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 5,  8'hAE, 1'b0};
        vecs[21] = '{1'b1, 8'h07, 1'b0, 1'b0, 8,  8'h07, 1'b0};
        vecs[22] = '{1'b1, 8'h01, 1'b0, 1'b0, 1,  8'h01, 1'b0};
        vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 4,  8'h01, 1'b0};
        vecs[24] = '{1'b0, 8'h00, 1'b0, 1'b0, 1,  8'h00, 1'b1};

        // Reset state, then release.
        repeat (2) @(negedge ClkIn);
        pushExp(8'h00, 1'b0, 1'b0);
        checkOut("reset_held");
        nRst = 1'b1;
        @(negedge ClkIn);
        pushExp(8'h00, 1'b0, 1'b0);
        checkOut("reset_release");

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].ld, vecs[i].val, vecs[i].st, vecs[i].sp, vecs[i].cyc,
                  vecs[i].expCnt, vecs[i].expDone, 1'b0, $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-RUN at count 5.
        drive(1'b1, 8'h05, 1'b0, 1'b0, 1, 8'h05, 1'b0, 1'b0, "mid_run_load");
        drive(1'b0, 8'h00, 1'b1, 1'b0, 3, 8'h05, 1'b0, 1'b0, "mid_run_started");
        @(posedge ClkIn);
        #2 nRst = 1'b0;
        #1;
        pushExp(8'h00, 1'b0, 1'b0);
        checkOut("async_reset");
        @(negedge ClkIn);
        nRst = 1'b1;
        repeat (12) @(negedge ClkIn);
        pushExp(8'h00, 1'b0, 1'b0);
        checkOut("no_tick_after_reset");

        // First edge after release evaluates Load.
        nRst = 1'b0;
        Load = 1'b1; LoadVal = 8'h33;
        @(negedge ClkIn);
        nRst = 1'b1;
        pushExp(8'h33, 1'b0, 1'b0);
        @(negedge ClkIn);
        Load = 1'b0;
        checkOut("first_edge_after_reset");

`ifdef COUNTDOWN_TIMER_BLINK_EN
        // Blink: lit edges 0..19 after DONE entry, blank 20..39, lit again at 40.
        drive(1'b1, 8'h01, 1'b0, 1'b0, 1, 8'h01, 1'b0, 1'b0, "blink_load");
        drive(1'b0, 8'h00, 1'b1, 1'b0, 5, 8'h00, 1'b1, 1'b0, "blink_done_entry");
        repeat (19) @(negedge ClkIn);
        pushExp(8'h00, 1'b1, 1'b0);
        checkOut("blink_last_lit");
        @(negedge ClkIn);
        pushExp(8'h00, 1'b1, 1'b1);
        checkOut("blink_first_blank");
        repeat (19) @(negedge ClkIn);
        pushExp(8'h00, 1'b1, 1'b1);
        checkOut("blink_last_blank");
        @(negedge ClkIn);
        pushExp(8'h00, 1'b1, 1'b0);
        checkOut("blink_relit");
        repeat (20) @(negedge ClkIn);
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1, 8'h22, 1'b0, 1'b0, "blink_load_ends");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
